// File: rtl/ucdp_fifo_pack_pkg.sv
// -----------------------------------------------------------------------------
// ucdp_fifo_pack_pkg
// Shared helpers for the narrow-to-wide FIFO packer (ucdp_fifo_pack).
//   calc_cntwidth : width of the lane counter for a given packing ratio.
//   lane_mask     : turns a count of filled lanes into a lane-valid mask
//                   (bit k set for every lane k < n), max_lanes_lp bits wide;
//                   callers size-cast the result down to their lane count.
// -----------------------------------------------------------------------------
package ucdp_fifo_pack_pkg;

  localparam int unsigned max_lanes_lp = 64;

  function automatic int unsigned calc_cntwidth(input int unsigned ratio);
    return $clog2(ratio);
  endfunction

  function automatic logic [max_lanes_lp-1:0] lane_mask(input int unsigned n);
    logic [max_lanes_lp-1:0] m;
    m = {max_lanes_lp{1'b0}};
    for (int unsigned k = 0; k < max_lanes_lp; k++) begin
      if (k < n) begin
        m[k] = 1'b1;
      end else begin
        m[k] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/ucdp_fifo_pack.sv
// -----------------------------------------------------------------------------
// ucdp_fifo_pack
// Packs ratio_p consecutive dwidth_p-bit words popped from a show-ahead FIFO
// read port into one wide beat on a valid/ready stream. Target clock domain.
//
// Optional feature: define UCDP_FIFO_PACK_FLUSH_EN to add flush_i, which
// emits a partially filled beat (unfilled lanes zero, mask marks filled lanes).
//
// Ports:
//   tgt_clk_i        clock
//   tgt_rst_an_i     synchronous active-low reset
//   fifo_rd_en_o     pop request (combinational, 0 during reset)
//   fifo_rd_data_i   FIFO head word
//   fifo_rd_empty_i  FIFO empty
//   out_valid_o      output beat valid
//   out_ready_i      downstream accepts beat
//   out_data_o       packed beat, lane 0 (bits [dwidth_p-1:0]) is the oldest
//   out_mask_o       lane-valid mask
//   flush_i          emit partial beat (only with UCDP_FIFO_PACK_FLUSH_EN)
//   busy_o           lanes filled or beat pending
// -----------------------------------------------------------------------------
module ucdp_fifo_pack
  import ucdp_fifo_pack_pkg::*;
#(
  parameter int unsigned dwidth_p = 8,
  parameter int unsigned ratio_p  = 4
) (
  input  logic                          tgt_clk_i,
  input  logic                          tgt_rst_an_i,
  output logic                          fifo_rd_en_o,
  input  logic [dwidth_p-1:0]           fifo_rd_data_i,
  input  logic                          fifo_rd_empty_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [dwidth_p*ratio_p-1:0]   out_data_o,
  output logic [ratio_p-1:0]            out_mask_o,
`ifdef UCDP_FIFO_PACK_FLUSH_EN
  input  logic                          flush_i,
`endif
  output logic                          busy_o
);

  localparam int unsigned cntwidth_p  = calc_cntwidth(ratio_p);
  localparam int unsigned accwidth_lp = (ratio_p - 1) * dwidth_p;
  localparam int unsigned owidth_lp   = ratio_p * dwidth_p;
  localparam logic [cntwidth_p-1:0] last_lp = cntwidth_p'(ratio_p - 1);

  logic [cntwidth_p-1:0]  cnt_q, cnt_d;
  logic [accwidth_lp-1:0] acc_q, acc_d;
  logic [owidth_lp-1:0]   out_data_q, out_data_d;
  logic [ratio_p-1:0]     out_mask_q, out_mask_d;
  logic                   out_valid_q, out_valid_d;

  logic stall_s;
  logic pop_s;
  logic drain_s;

`ifdef UCDP_FIFO_PACK_FLUSH_EN
  logic                  flush_pend_q, flush_pend_d;
  logic [cntwidth_p:0]   filled_s;
`endif

  // Pop/stall decision: only the last lane (or a pending flush) waits on a busy output register.
  always_comb begin
    stall_s = 1'b0;
    pop_s   = 1'b0;
    drain_s = out_valid_q & out_ready_i;
`ifdef UCDP_FIFO_PACK_FLUSH_EN
    stall_s = ((cnt_q == last_lp) | flush_pend_q) & out_valid_q & ~out_ready_i;
`else
    stall_s = (cnt_q == last_lp) & out_valid_q & ~out_ready_i;
`endif
    if (tgt_rst_an_i) begin
      pop_s = ~fifo_rd_empty_i & ~stall_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Next-state: drain, lane accumulation, full-beat load and optional flush.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_valid_d = out_valid_q;
`ifdef UCDP_FIFO_PACK_FLUSH_EN
    flush_pend_d = flush_pend_q | flush_i;
    filled_s     = {1'b0, cnt_q} + {{cntwidth_p{1'b0}}, pop_s};
`endif

    // A transferred beat leaves the register empty unless reloaded below.
    if (drain_s) begin
      out_valid_d = 1'b0;
      out_mask_d  = {ratio_p{1'b0}};
    end else begin
      out_valid_d = out_valid_q;
    end

    if (pop_s) begin
      if (cnt_q == last_lp) begin
        out_data_d  = {fifo_rd_data_i, acc_q};
        out_mask_d  = {ratio_p{1'b1}};
        out_valid_d = 1'b1;
        cnt_d       = {cntwidth_p{1'b0}};
        acc_d       = {accwidth_lp{1'b0}};
      end else begin
        cnt_d = cnt_q + cntwidth_p'(1);
        for (int unsigned k = 0; k < ratio_p - 1; k++) begin
          if (cnt_q == cntwidth_p'(k)) begin
            acc_d[k*dwidth_p +: dwidth_p] = fifo_rd_data_i;
          end else begin
            acc_d[k*dwidth_p +: dwidth_p] = acc_q[k*dwidth_p +: dwidth_p];
          end
        end
      end
    end else begin
      cnt_d = cnt_q;
    end

`ifdef UCDP_FIFO_PACK_FLUSH_EN
    if (flush_pend_d) begin
      if (pop_s && (cnt_q == last_lp)) begin
        // The full beat already carries every lane; the flush has nothing left.
        flush_pend_d = 1'b0;
      end else if (!out_valid_q || out_ready_i) begin
        if (filled_s != {(cntwidth_p + 1){1'b0}}) begin
          // acc_d already holds any same-cycle pop; lanes beyond the fill
          // point are zero because the accumulator is cleared per beat.
          out_data_d  = {{dwidth_p{1'b0}}, acc_d};
          out_mask_d  = ratio_p'(lane_mask(32'(filled_s)));
          out_valid_d = 1'b1;
          cnt_d       = {cntwidth_p{1'b0}};
          acc_d       = {accwidth_lp{1'b0}};
        end else begin
          cnt_d = cnt_q;
        end
        flush_pend_d = 1'b0;
      end else begin
        flush_pend_d = 1'b1;
      end
    end else begin
      flush_pend_d = 1'b0;
    end
`endif
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge tgt_clk_i) begin
    if (!tgt_rst_an_i) begin
      cnt_q        <= {cntwidth_p{1'b0}};
      acc_q        <= {accwidth_lp{1'b0}};
      out_data_q   <= {owidth_lp{1'b0}};
      out_mask_q   <= {ratio_p{1'b0}};
      out_valid_q  <= 1'b0;
`ifdef UCDP_FIFO_PACK_FLUSH_EN
      flush_pend_q <= 1'b0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      out_data_q   <= out_data_d;
      out_mask_q   <= out_mask_d;
      out_valid_q  <= out_valid_d;
`ifdef UCDP_FIFO_PACK_FLUSH_EN
      flush_pend_q <= flush_pend_d;
`endif
    end
  end

  assign fifo_rd_en_o = pop_s;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_mask_o   = out_mask_q;
  assign busy_o       = (cnt_q != {cntwidth_p{1'b0}}) | out_valid_q;

endmodule

// File: tb/tb_ucdp_fifo_pack.sv
// -----------------------------------------------------------------------------
// tb_ucdp_fifo_pack
// Directed bench for ucdp_fifo_pack (dwidth_p=8, ratio_p=4). A queue models
// the show-ahead FIFO; a per-cycle vector table covers reset and a basic beat,
// hand-written sequences cover backpressure, an empty FIFO, mid-beat reset and
// (with UCDP_FIFO_PACK_FLUSH_EN) flush behaviour.
// -----------------------------------------------------------------------------
module tb_ucdp_fifo_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        empty;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic [3:0]  mask;
  logic        busy;
`ifdef UCDP_FIFO_PACK_FLUSH_EN
  logic        flush;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] q[$];

  typedef struct {
    logic        rst_n;
    logic        ready;
    logic        push;
    logic [7:0]  word;
    logic        e_valid;
    logic [31:0] e_data;
    logic [3:0]  e_mask;
    logic        e_busy;
    logic        e_rd_en;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  ucdp_fifo_pack #(.dwidth_p(8), .ratio_p(4)) dut (
    .tgt_clk_i       (clk),
    .tgt_rst_an_i    (rst_n),
    .fifo_rd_en_o    (rd_en),
    .fifo_rd_data_i  (rd_data),
    .fifo_rd_empty_i (empty),
    .out_valid_o     (valid),
    .out_ready_i     (ready),
    .out_data_o      (data),
    .out_mask_o      (mask),
`ifdef UCDP_FIFO_PACK_FLUSH_EN
    .flush_i         (flush),
`endif
    .busy_o          (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_fifo();
    empty   = (q.size() == 0);
    rd_data = (q.size() == 0) ? 8'h00 : q[0];
  endtask

  // One clock: sample the pop request, clock, retire the popped word.
  task automatic tick();
    logic popped;
    apply_fifo();
    #1;
    popped = rd_en;
    @(posedge clk);
    #1;
    if (popped === 1'b1 && q.size() > 0) void'(q.pop_front());
    apply_fifo();
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    q.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ready = 1'b1;
`ifdef UCDP_FIFO_PACK_FLUSH_EN
    flush = 1'b0;
`endif
    apply_fifo();

    //          rst   rdy   push  word   vld   data          mask  busy  rd_en
    tbl[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0000_0000, 4'h0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 32'h0000_0000, 4'h0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 32'h0000_0000, 4'h0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 8'h44, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h4433_2211, 4'hF, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0000_0000, 4'h0, 1'b0, 1'b0};

    tick();
    tick();

    // Vector table: reset values, rd_en forced low in reset, one full beat.
    for (int i = 0; i < 8; i++) begin
      rst_n = tbl[i].rst_n;
      ready = tbl[i].ready;
      if (tbl[i].push) q.push_back(tbl[i].word);
      apply_fifo();
      #1;
      chk($sformatf("vec%0d.valid", i), {31'd0, valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("vec%0d.mask", i), {28'd0, mask}, {28'd0, tbl[i].e_mask});
      chk($sformatf("vec%0d.busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
      chk($sformatf("vec%0d.rd_en", i), {31'd0, rd_en}, {31'd0, tbl[i].e_rd_en});
      if (i == 0 || tbl[i].e_valid) chk($sformatf("vec%0d.data", i), data, tbl[i].e_data);
      tick();
    end

    // Backpressure: ready low until cycle 10, 0x08 pop stalls, then drain+load.
    reset_dut();
    ready = 1'b0;
    for (int w = 1; w <= 8; w++) q.push_back(8'(w));
    for (int t = 0; t < 12; t++) begin
      if (t == 10) ready = 1'b1;
      apply_fifo();
      #1;
      if (t == 3) chk("bp.valid_before", {31'd0, valid}, 32'd0);
      if (t >= 4 && t <= 10) begin
        chk($sformatf("bp.hold_valid%0d", t), {31'd0, valid}, 32'd1);
        chk($sformatf("bp.hold_data%0d", t), data, 32'h0403_0201);
      end
      if (t >= 4 && t <= 6) chk($sformatf("bp.fill%0d", t), {31'd0, rd_en}, 32'd1);
      if (t >= 7 && t <= 9) begin
        chk($sformatf("bp.stall%0d", t), {31'd0, rd_en}, 32'd0);
        chk($sformatf("bp.mask%0d", t), {28'd0, mask}, 32'hF);
      end
      if (t == 10) chk("bp.resume", {31'd0, rd_en}, 32'd1);
      if (t == 11) begin
        chk("bp.reload_valid", {31'd0, valid}, 32'd1);
        chk("bp.reload_data", data, 32'h0807_0605);
        chk("bp.reload_mask", {28'd0, mask}, 32'hF);
      end
      tick();
    end
    chk("bp.idle_valid", {31'd0, valid}, 32'd0);
    chk("bp.idle_busy", {31'd0, busy}, 32'd0);

    // FIFO runs dry after two words, refills 20 cycles later.
    reset_dut();
    ready = 1'b1;
    q.push_back(8'h01);
    q.push_back(8'h02);
    for (int t = 0; t < 22; t++) begin
      apply_fifo();
      #1;
      if (t == 2 || t == 21) begin
        chk($sformatf("dry.busy%0d", t), {31'd0, busy}, 32'd1);
        chk($sformatf("dry.valid%0d", t), {31'd0, valid}, 32'd0);
        chk($sformatf("dry.rd_en%0d", t), {31'd0, rd_en}, 32'd0);
      end
      tick();
    end
    q.push_back(8'h03);
    q.push_back(8'h04);
    tick();
    tick();
    chk("dry.valid", {31'd0, valid}, 32'd1);
    chk("dry.data", data, 32'h0403_0201);

    // Reset with three lanes filled discards them.
    reset_dut();
    ready = 1'b1;
    q.push_back(8'h01);
    q.push_back(8'h02);
    q.push_back(8'h03);
    tick();
    tick();
    tick();
    q.push_back(8'h99);
    rst_n = 1'b0;
    apply_fifo();
    #1;
    chk("rst.rd_en_forced", {31'd0, rd_en}, 32'd0);
    tick();
    chk("rst.valid", {31'd0, valid}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.rd_en", {31'd0, rd_en}, 32'd0);
    chk("rst.data", data, 32'd0);
    rst_n = 1'b1;
    q.push_back(8'hA1);
    q.push_back(8'hA2);
    q.push_back(8'hA3);
    tick();
    tick();
    tick();
    tick();
    chk("rst.clean_valid", {31'd0, valid}, 32'd1);
    chk("rst.clean_data", data, 32'hA3A2_A199);
    chk("rst.clean_mask", {28'd0, mask}, 32'hF);

`ifdef UCDP_FIFO_PACK_FLUSH_EN
    // Flush with two lanes filled.
    reset_dut();
    ready = 1'b1;
    flush = 1'b0;
    q.push_back(8'hAA);
    q.push_back(8'hBB);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("fl2.valid", {31'd0, valid}, 32'd1);
    chk("fl2.data", data, 32'h0000_BBAA);
    chk("fl2.mask", {28'd0, mask}, 32'h3);
    tick();
    chk("fl2.drained", {31'd0, valid}, 32'd0);
    chk("fl2.busy", {31'd0, busy}, 32'd0);

    // Flush with nothing filled produces no beat.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("fl0.valid", {31'd0, valid}, 32'd0);
    tick();
    chk("fl0.valid_late", {31'd0, valid}, 32'd0);
    chk("fl0.busy", {31'd0, busy}, 32'd0);

    // Flush together with the third pop, then a normal full beat follows.
    q.push_back(8'h01);
    q.push_back(8'h02);
    q.push_back(8'h03);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("fl3.valid", {31'd0, valid}, 32'd1);
    chk("fl3.data", data, 32'h0003_0201);
    chk("fl3.mask", {28'd0, mask}, 32'h7);
    q.push_back(8'h04);
    q.push_back(8'h05);
    q.push_back(8'h06);
    q.push_back(8'h07);
    tick();
    tick();
    tick();
    tick();
    chk("fl3.next_valid", {31'd0, valid}, 32'd1);
    chk("fl3.next_data", data, 32'h0706_0504);
    chk("fl3.next_mask", {28'd0, mask}, 32'hF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
